// File: rtl/sad_best_match_if.sv
// Handshake bundle between SAD datapath control and the best-match tracker.
// The master drives the window strobes; the slave reports the winner.
interface sad_best_match_if #(
  parameter int SAD_WIDTH = 13,
  parameter int IDX_WIDTH = 4
);
  logic                 start;
  logic                 sad_valid;
  logic [SAD_WIDTH-1:0] sad_in;
  logic                 busy;
  logic                 done;
  logic [SAD_WIDTH-1:0] best_sad;
  logic [IDX_WIDTH-1:0] best_idx;

  modport master (
    output start,
    output sad_valid,
    output sad_in,
    input  busy,
    input  done,
    input  best_sad,
    input  best_idx
  );

  modport slave (
    input  start,
    input  sad_valid,
    input  sad_in,
    output busy,
    output done,
    output best_sad,
    output best_idx
  );
endinterface

// File: rtl/sad_best_match.sv
// Tracks the minimum SAD over a window of NUM_CAND candidates and
// reports the value and arrival index with a one-cycle done pulse.
module sad_best_match #(
  parameter int SAD_WIDTH = 13,
  parameter int NUM_CAND  = 16,
  parameter int IDX_WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  sad_best_match_if.slave   bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEARCH = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX =
    IDX_WIDTH'(NUM_CAND - 1);

  logic [1:0]           r_state;
  logic [IDX_WIDTH-1:0] r_cnt;
  logic [SAD_WIDTH-1:0] r_cur_min;
  logic [IDX_WIDTH-1:0] r_cur_idx;
  logic [SAD_WIDTH-1:0] r_best_sad;
  logic [IDX_WIDTH-1:0] r_best_idx;

  logic                 w_take;
  logic                 w_last;
  logic [SAD_WIDTH-1:0] w_min;
  logic [IDX_WIDTH-1:0] w_idx;

  // First sample always seeds; later ones win only when strictly smaller.
  assign w_take = (r_cnt == '0) || (bus.sad_in < r_cur_min);
  assign w_min  = w_take ? bus.sad_in : r_cur_min;
  assign w_idx  = w_take ? r_cnt : r_cur_idx;
  assign w_last = (r_cnt == LAST_IDX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_cur_min  <= '0;
      r_cur_idx  <= '0;
      r_best_sad <= '0;
      r_best_idx <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state <= S_SEARCH;
            r_cnt   <= '0;
          end
        end
        S_SEARCH: begin
          if (bus.sad_valid) begin
            r_cur_min <= w_min;
            r_cur_idx <= w_idx;
            if (w_last) begin
              r_best_sad <= w_min;
              r_best_idx <= w_idx;
              r_state    <= S_DONE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = (r_state == S_SEARCH);
  assign bus.done     = (r_state == S_DONE);
  assign bus.best_sad = r_best_sad;
  assign bus.best_idx = r_best_idx;

endmodule
